// File: rtl/stripes_psum_accumulator.sv
// Partial-sum accumulator behind the Stripes bit-serial multiplier: sums `len` signed products
// and holds the total on a valid/ready port. Define ACC_SAT_EN for saturating adds.
module stripes_psum_accumulator #(
  parameter int MAX_PRECISION = 16,
  parameter int ACC_WIDTH     = 48,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                         clk_gate,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic                         prod_valid_i,
  input  logic [2*MAX_PRECISION-1:0]   prod_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [ACC_WIDTH-1:0]         out_data_o,
  output logic                         busy_o,
  output logic                         drop_err_o,
  output logic                         sat_flag_o
);
  localparam int PROD_WIDTH = 2 * MAX_PRECISION;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 drop_err_q, drop_err_d;
  logic                 out_valid_q, busy_q;
  logic [ACC_WIDTH-1:0] prod_ext, sum;
  logic                 start_ok, add_en;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data_i[PROD_WIDTH-1]}}, prod_data_i};

`ifdef ACC_SAT_EN
  // One guard bit above the accumulator exposes signed overflow of each add.
  logic [ACC_WIDTH:0] wide_sum;
  logic               clamp;
  logic               sat_q, sat_d;

  assign wide_sum = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
  assign clamp    = wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1];

  always_comb begin
    sum = wide_sum[ACC_WIDTH-1:0];
    if (clamp) sum = wide_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_comb begin
    sat_d = sat_q;
    if (start_ok) sat_d = 1'b0;
    if (add_en && clamp) sat_d = 1'b1;
  end

  always_ff @(posedge clk_gate or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign sat_flag_o = sat_q;
`else
  assign sum        = acc_q + prod_ext;
  assign sat_flag_o = 1'b0;
`endif

  // A start is taken in IDLE, or in HOLD together with the output handshake.
  assign start_ok = start_i && ((state_q == IDLE) || ((state_q == HOLD) && out_ready_i));
  assign add_en   = (state_q == ACCUM) && prod_valid_i;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    drop_err_d = drop_err_q;
    case (state_q)
      ACCUM: begin
        if (prod_valid_i) begin
          acc_d = sum;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            out_data_d = sum;
            state_d    = HOLD;
          end
        end
      end
      HOLD:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_ok) begin
      acc_d      = '0;
      cnt_d      = len_i;
      drop_err_d = 1'b0;
      if (len_i == '0) begin
        state_d    = HOLD;
        out_data_d = '0;
      end else begin
        state_d = ACCUM;
      end
    end
    // Set after the start-clear so a product coinciding with start is still flagged.
    if (prod_valid_i && (state_q != ACCUM)) drop_err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update on the same edge.
  always_ff @(posedge clk_gate or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      drop_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      drop_err_q  <= drop_err_d;
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;
  assign drop_err_o  = drop_err_q;
endmodule

// File: tb/tb_stripes_psum_accumulator.sv
// Scoreboard bench for stripes_psum_accumulator: directed scenarios then randomized sums,
// checked against an arithmetic reference model (honours ACC_SAT_EN).
module tb_stripes_psum_accumulator;
  localparam int MP    = 16;
  localparam int ACC_W = 33;
  localparam int LW    = 8;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             sat;
  } exp_t;

  logic              clk_gate = 1'b0;
  logic              rst_n    = 1'b0;
  logic              start_i = 1'b0, prod_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [LW-1:0]     len_i = '0;
  logic [2*MP-1:0]   prod_data_i = '0;
  logic              out_valid_o, busy_o, drop_err_o, sat_flag_o;
  logic [ACC_W-1:0]  out_data_o;

  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  exp_t   cur;
  longint prods[16];
  int     n;
  bit     chained;

  stripes_psum_accumulator #(.MAX_PRECISION(MP), .ACC_WIDTH(ACC_W), .LEN_WIDTH(LW)) u_dut (
    .clk_gate(clk_gate), .rst_n(rst_n), .start_i(start_i), .len_i(len_i),
    .prod_valid_i(prod_valid_i), .prod_data_i(prod_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .busy_o(busy_o),
    .drop_err_o(drop_err_o), .sat_flag_o(sat_flag_o)
  );

  always #5 clk_gate = ~clk_gate;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the products, clamped per add or wrapped at the end.
  function automatic exp_t model_sum(input int cnt);
    longint s = 0;
    exp_t   e;
    e.sat = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      s += prods[i];
`ifdef ACC_SAT_EN
      if (s > ACC_MAX) begin s = ACC_MAX; e.sat = 1'b1; end
      else if (s < ACC_MIN) begin s = ACC_MIN; e.sat = 1'b1; end
`endif
    end
    e.data = ACC_W'(s);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_gate);
    #1;
  endtask

  task automatic send_prod(input longint p, input int gap);
    repeat (gap) tick();
    prod_valid_i = 1'b1;
    prod_data_i  = p[2*MP-1:0];
    tick();
    prod_valid_i = 1'b0;
  endtask

  task automatic issue_start(input int cnt);
    start_i = 1'b1;
    len_i   = LW'(cnt);
    tick();
    start_i = 1'b0;
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic gen_prods(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      case ($urandom_range(0, 3))
        0:       prods[i] = longint'($urandom_range(0, 200)) - 100;
        1:       prods[i] = 64'sh7FFF_FFFF;
        2:       prods[i] = -64'sh8000_0000;
        default: prods[i] = longint'(int'($urandom));
      endcase
    end
  endtask

  // Monitor: every output handshake pops one expected sum.
  always @(negedge clk_gate) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(out_valid_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_data", 64'(out_data_o), 64'(mon_e.data));
        check("sb_sat", 64'(sat_flag_o), 64'(mon_e.sat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_gate);
    #1;
    check("rst_valid", 64'(out_valid_o), 0);
    check("rst_data", 64'(out_data_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_drop", 64'(drop_err_o), 0);
    check("rst_sat", 64'(sat_flag_o), 0);
    rst_n = 1'b1;
    tick();

    // Basic sum 6 - 10 + 100 on non-consecutive cycles.
    prods[0] = 6; prods[1] = -10; prods[2] = 100;
    sb.push_back(model_sum(3));
    issue_start(3);
    check("basic_busy", 64'(busy_o), 1);
    check("basic_valid_early", 64'(out_valid_o), 0);
    send_prod(prods[0], 1);
    send_prod(prods[1], 2);
    check("basic_valid_mid", 64'(out_valid_o), 0);
    send_prod(prods[2], 1);
    check("basic_valid", 64'(out_valid_o), 1);
    check("basic_data", 64'(out_data_o), 96);
    check("basic_busy_hold", 64'(busy_o), 1);
    handshake();
    check("basic_idle_busy", 64'(busy_o), 0);
    check("basic_idle_valid", 64'(out_valid_o), 0);

    // Zero length: result appears next cycle and holds under backpressure.
    sb.push_back(model_sum(0));
    issue_start(0);
    for (int i = 0; i < 5; i++) begin
      check("zero_valid", 64'(out_valid_o), 1);
      check("zero_data", 64'(out_data_o), 0);
      tick();
    end
    handshake();

    // Drop while holding, then a product coinciding with start in IDLE.
    prods[0] = 7;
    sb.push_back(model_sum(1));
    issue_start(1);
    send_prod(prods[0], 0);
    check("drop_pre", 64'(drop_err_o), 0);
    send_prod(9, 0);
    check("drop_set", 64'(drop_err_o), 1);
    check("drop_data_kept", 64'(out_data_o), 7);
    check("drop_valid_kept", 64'(out_valid_o), 1);
    handshake();
    prods[0] = 20;
    sb.push_back(model_sum(1));
    start_i = 1'b1; len_i = 8'd1; prod_valid_i = 1'b1; prod_data_i = 32'd9;
    tick();
    start_i = 1'b0; prod_valid_i = 1'b0;
    check("drop_with_start", 64'(drop_err_o), 1);
    send_prod(prods[0], 0);
    check("drop_start_data", 64'(out_data_o), 20);

    // Chained start on the handshake cycle: -1 + -1.
    prods[0] = -1; prods[1] = -1;
    sb.push_back(model_sum(2));
    out_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd2;
    tick();
    out_ready_i = 1'b0; start_i = 1'b0;
    check("chain_drop_clear", 64'(drop_err_o), 0);
    check("chain_busy", 64'(busy_o), 1);
    check("chain_valid_low", 64'(out_valid_o), 0);
    send_prod(prods[0], 0);
    send_prod(prods[1], 0);
    check("chain_data", 64'(out_data_o), 64'(33'h1_FFFF_FFFE));
    handshake();

    // Three maximal products overflow a 33-bit accumulator.
    for (int i = 0; i < 3; i++) prods[i] = 64'sh7FFF_FFFF;
    sb.push_back(model_sum(3));
    issue_start(3);
    for (int i = 0; i < 3; i++) send_prod(prods[i], 0);
`ifdef ACC_SAT_EN
    check("sat_data", 64'(out_data_o), 64'(33'h0_FFFF_FFFF));
    check("sat_flag", 64'(sat_flag_o), 1);
`else
    check("wrap_data", 64'(out_data_o), 64'(33'h1_7FFF_FFFD));
    check("wrap_flag", 64'(sat_flag_o), 0);
`endif
    handshake();

    // Reset mid-sum discards the partial result.
    issue_start(4);
    send_prod(1000, 0);
    send_prod(2000, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid_o), 0);
    check("mid_rst_busy", 64'(busy_o), 0);
    check("mid_rst_data", 64'(out_data_o), 0);
    check("mid_rst_drop", 64'(drop_err_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid_o), 0);
    prods[0] = 5;
    sb.push_back(model_sum(1));
    issue_start(1);
    send_prod(prods[0], 0);
    check("post_rst_data", 64'(out_data_o), 5);
    handshake();

    // Randomized sums with gaps, backpressure and chained starts.
    n = $urandom_range(0, 6);
    gen_prods(n);
    cur = model_sum(n);
    sb.push_back(cur);
    issue_start(n);
    for (int t = 0; t < 40; t++) begin
      check("rnd_busy", 64'(busy_o), 1);
      for (int i = 0; i < n; i++) send_prod(prods[i], $urandom_range(0, 2));
      check("rnd_valid", 64'(out_valid_o), 1);
      repeat ($urandom_range(0, 3)) begin
        check("rnd_hold_data", 64'(out_data_o), 64'(cur.data));
        tick();
      end
      chained = (t != 39) && ($urandom_range(0, 2) == 0);
      out_ready_i = 1'b1;
      if (chained) begin
        n = $urandom_range(0, 6);
        gen_prods(n);
        cur = model_sum(n);
        sb.push_back(cur);
        start_i = 1'b1;
        len_i   = LW'(n);
      end
      tick();
      out_ready_i = 1'b0;
      start_i     = 1'b0;
      if (chained) begin
        check("rnd_chain_valid", 64'(out_valid_o), 64'(n == 0));
      end else begin
        check("rnd_idle_busy", 64'(busy_o), 0);
        check("rnd_idle_valid", 64'(out_valid_o), 0);
        if (t != 39) begin
          repeat ($urandom_range(0, 2)) tick();
          n = $urandom_range(0, 6);
          gen_prods(n);
          cur = model_sum(n);
          sb.push_back(cur);
          issue_start(n);
        end
      end
    end

    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
